// File: rtl/iter_divider_if.sv
// ============================================================================
// iter_divider_if : request/response bundle between the ALU and iter_divider
// Revision 1.0
// ============================================================================
`default_nettype none

interface iter_divider_if #(
  parameter int XLEN = 64
);
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            div_valid;
  logic            divw;
  logic            div_signed;
  logic            flush;
  logic            div_ready;
  logic            out_valid;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;

  modport master (
    output dividend, divisor, div_valid, divw, div_signed, flush,
    input  div_ready, out_valid, quotient, remainder
  );

  modport slave (
    input  dividend, divisor, div_valid, divw, div_signed, flush,
    output div_ready, out_valid, quotient, remainder
  );
endinterface

`default_nettype wire

// File: rtl/iter_divider.sv
// ============================================================================
// iter_divider : iterative radix-2 restoring divider for RV64M DIV/REM (+W)
// Revision 1.0
// ============================================================================
`default_nettype none

module iter_divider #(
  parameter int XLEN = 64
) (
  input  logic           clk,
  input  logic           rst,
  iter_divider_if.slave  div_if
);

  localparam int HALF  = XLEN / 2;
  localparam int CNT_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic [CNT_W-1:0] count;
  logic            w_op;
  logic            q_neg;
  logic            r_neg;
  logic [XLEN-1:0] res_quo;
  logic [XLEN-1:0] res_rem;

  logic            ready;
  logic            valid_out;
  logic            accept;

  function automatic logic [XLEN-1:0] sext_half(input logic [HALF-1:0] v);
    return {{HALF{v[HALF-1]}}, v};
  endfunction

  // ---------------- operand conditioning at accept ----------------
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] load_quo;
  logic            div_zero;
  logic            overflow;
  logic            special;
  logic [XLEN-1:0] sp_quo;
  logic [XLEN-1:0] sp_rem;
  logic [XLEN-1:0] min_full;
  logic [XLEN-1:0] min_w;

  assign min_full = {1'b1, {(XLEN-1){1'b0}}};
  assign min_w    = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};

  always_comb begin
    if (div_if.divw) begin
      a_ext = div_if.div_signed ? sext_half(div_if.dividend[HALF-1:0])
                                : {{HALF{1'b0}}, div_if.dividend[HALF-1:0]};
      b_ext = div_if.div_signed ? sext_half(div_if.divisor[HALF-1:0])
                                : {{HALF{1'b0}}, div_if.divisor[HALF-1:0]};
    end else begin
      a_ext = div_if.dividend;
      b_ext = div_if.divisor;
    end
  end

  assign a_neg = div_if.div_signed & a_ext[XLEN-1];
  assign b_neg = div_if.div_signed & b_ext[XLEN-1];
  assign a_mag = a_neg ? (~a_ext + 1'b1) : a_ext;
  assign b_mag = b_neg ? (~b_ext + 1'b1) : b_ext;

  // W dividends are left-aligned so every step shifts out of the same MSB
  assign load_quo = div_if.divw ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;

  assign div_zero = (b_ext == '0);
  assign overflow = div_if.div_signed && (b_ext == '1) &&
                    (a_ext == (div_if.divw ? min_w : min_full));
  assign special  = div_zero || overflow;

  assign sp_quo = div_zero ? '1 : a_ext;
  always_comb begin
    if (!div_zero)
      sp_rem = '0;
    else if (div_if.divw)
      sp_rem = sext_half(div_if.dividend[HALF-1:0]);
    else
      sp_rem = div_if.dividend;
  end

  // ---------------- one restoring step ----------------
  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] trial;
  logic            borrow;
  logic [XLEN:0]   rem_next;
  logic [XLEN-1:0] quo_next;

  assign shifted  = {rem_q, quo_q[XLEN-1]};
  assign trial    = shifted - {2'b00, dvs_q};
  assign borrow   = trial[XLEN+1];
  assign rem_next = borrow ? shifted[XLEN:0] : trial[XLEN:0];
  assign quo_next = {quo_q[XLEN-2:0], ~borrow};

  // ---------------- sign fix-up ----------------
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] fin_quo;
  logic [XLEN-1:0] fin_rem;

  assign q_fix   = q_neg ? (~quo_q + 1'b1) : quo_q;
  assign r_fix   = r_neg ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];
  assign fin_quo = w_op ? sext_half(q_fix[HALF-1:0]) : q_fix;
  assign fin_rem = w_op ? sext_half(r_fix[HALF-1:0]) : r_fix;

  // ---------------- control FSM ----------------
  assign ready  = (state == IDLE);
  assign accept = div_if.div_valid && ready && !div_if.flush;

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    valid_out  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept)
          state_next = special ? DONE : CALC;
      end
      CALC: begin
        if (count == CNT_W'(1))
          state_next = FIX;
      end
      FIX: begin
        state_next = DONE;
      end
      DONE: begin
        valid_out  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // flush overrides everything, including a pending DONE pulse
    if (div_if.flush) begin
      state_next = IDLE;
      valid_out  = 1'b0;
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      count   <= '0;
      w_op    <= 1'b0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      res_quo <= '0;
      res_rem <= '0;
    end else if (accept) begin
      rem_q <= '0;
      quo_q <= load_quo;
      dvs_q <= b_mag;
      count <= div_if.divw ? CNT_W'(HALF) : CNT_W'(XLEN);
      w_op  <= div_if.divw;
      q_neg <= a_neg ^ b_neg;
      r_neg <= a_neg;
      if (special) begin
        res_quo <= sp_quo;
        res_rem <= sp_rem;
      end
    end else if (state == CALC && !div_if.flush) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
      count <= count - CNT_W'(1);
    end else if (state == FIX && !div_if.flush) begin
      res_quo <= fin_quo;
      res_rem <= fin_rem;
    end
  end

  assign div_if.div_ready = ready;
  assign div_if.out_valid = valid_out;
  assign div_if.quotient  = res_quo;
  assign div_if.remainder = res_rem;

endmodule

`default_nettype wire

// File: tb/tb_iter_divider.sv
// ============================================================================
// tb_iter_divider : vector table, corner sequences and random ops vs a model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_iter_divider;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  iter_divider_if #(.XLEN(64)) bus ();

  iter_divider #(.XLEN(64)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          w;
    bit          s;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input bit w, input bit s,
                              input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] q, input logic [63:0] r,
                              input int lat);
    vec_t v;
    v.name = name; v.w = w; v.s = s; v.a = a; v.b = b;
    v.q = q; v.r = r; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // RISC-V M semantics from plain integer arithmetic
  function automatic void ref_div(input logic [63:0] a, input logic [63:0] b,
                                  input bit w, input bit s,
                                  output logic [63:0] q, output logic [63:0] r,
                                  output int lat);
    longint      sa;
    longint      sb;
    logic [63:0] ua;
    logic [63:0] ub;
    if (w) begin
      if (s) begin
        sa = longint'($signed(a[31:0]));
        sb = longint'($signed(b[31:0]));
      end else begin
        sa = longint'({32'd0, a[31:0]});
        sb = longint'({32'd0, b[31:0]});
      end
      if (sb == 0) begin
        q = '1; r = sa; lat = 1;
      end else if (s && sa == 64'shFFFF_FFFF_8000_0000 && sb == -1) begin
        q = sa; r = '0; lat = 1;
      end else begin
        q = sa / sb; r = sa % sb; lat = 34;
      end
      q = {{32{q[31]}}, q[31:0]};
      r = {{32{r[31]}}, r[31:0]};
    end else if (s) begin
      sa = a; sb = b;
      if (sb == 0) begin
        q = '1; r = sa; lat = 1;
      end else if (sa == 64'sh8000_0000_0000_0000 && sb == -1) begin
        q = sa; r = '0; lat = 1;
      end else begin
        q = sa / sb; r = sa % sb; lat = 66;
      end
    end else begin
      ua = a; ub = b;
      if (ub == 0) begin
        q = '1; r = ua; lat = 1;
      end else begin
        q = ua / ub; r = ua % ub; lat = 66;
      end
    end
  endfunction

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (!bus.div_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input bit w, input bit s,
                        output logic [63:0] q, output logic [63:0] r, output int lat);
    wait_ready();
    bus.dividend   = a;
    bus.divisor    = b;
    bus.divw       = w;
    bus.div_signed = s;
    bus.div_valid  = 1'b1;
    #1;
    chk("no_out_valid_in_accept_cycle", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    bus.div_valid = 1'b0;
    lat = 0;
    q   = 'x;
    r   = 'x;
    for (int k = 1; k <= 200; k++) begin
      if (bus.out_valid) begin
        lat = k;
        q   = bus.quotient;
        r   = bus.remainder;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat != 0) begin
      @(posedge clk); #1;
      chk("out_valid_single_pulse", 64'(bus.out_valid), 64'd0);
      chk("ready_after_done", 64'(bus.div_ready), 64'd1);
    end
  endtask

  task automatic count_ov(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      if (bus.out_valid) cnt++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] q;
    logic [63:0] r;
    logic [63:0] eq;
    logic [63:0] er;
    logic [63:0] a;
    logic [63:0] b;
    int          lat;
    int          elat;
    int          cnt;
    bit          w;
    bit          s;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.dividend = '0; bus.divisor = '0; bus.div_valid = 1'b0;
    bus.divw = 1'b0; bus.div_signed = 1'b0; bus.flush = 1'b0;

    vecs.push_back(mk("div_m7_2",      0, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                      64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 66));
    vecs.push_back(mk("divuw_8000",    1, 0, 64'h0000_0000_8000_0000, 64'd1,
                      64'hFFFF_FFFF_8000_0000, 64'd0, 34));
    vecs.push_back(mk("divu_5_0",      0, 0, 64'd5, 64'd0,
                      64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1));
    vecs.push_back(mk("remw_x_0",      1, 1, 64'h0000_0001_0000_0005, 64'd0,
                      64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1));
    vecs.push_back(mk("div_ovf",       0, 1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                      64'h8000_0000_0000_0000, 64'd0, 1));
    vecs.push_back(mk("divw_ovf",      1, 1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                      64'hFFFF_FFFF_8000_0000, 64'd0, 1));
    vecs.push_back(mk("divu_100_7",    0, 0, 64'd100, 64'd7, 64'd14, 64'd2, 66));
    vecs.push_back(mk("div_7_m2",      0, 1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
                      64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 66));
    vecs.push_back(mk("divw_m7_2",     1, 1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002,
                      64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 34));
    vecs.push_back(mk("divu_max_1",    0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                      64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 66));
    vecs.push_back(mk("divuw_ff_10",   1, 0, 64'h7777_0000_FFFF_FFFF, 64'h1111_0000_0000_0010,
                      64'h0000_0000_0FFF_FFFF, 64'd15, 34));
    vecs.push_back(mk("divuw_x_0",     1, 0, 64'h0000_0005_8000_0001, 64'hFFFF_FFFF_0000_0000,
                      64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 1));
    vecs.push_back(mk("div_min_1",     0, 1, 64'h8000_0000_0000_0000, 64'd1,
                      64'h8000_0000_0000_0000, 64'd0, 66));

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_div_ready", 64'(bus.div_ready), 64'd1);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_quotient", bus.quotient, 64'd0);
    chk("reset_remainder", bus.remainder, 64'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].w, vecs[i].s, q, r, lat);
      chk({vecs[i].name, "/quotient"}, q, vecs[i].q);
      chk({vecs[i].name, "/remainder"}, r, vecs[i].r);
      chk({vecs[i].name, "/latency"}, 64'(lat), 64'(vecs[i].lat));
    end

    // results hold while idle
    repeat (5) @(posedge clk);
    #1;
    chk("hold_quotient", bus.quotient, 64'h8000_0000_0000_0000);
    chk("hold_remainder", bus.remainder, 64'd0);

    // flush in T+10 of a 64-bit op
    wait_ready();
    bus.dividend = 64'd1000; bus.divisor = 64'd3; bus.divw = 1'b0; bus.div_signed = 1'b0;
    bus.div_valid = 1'b1;
    @(posedge clk); #1;
    bus.div_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_ready_next", 64'(bus.div_ready), 64'd1);
    count_ov(80, cnt);
    chk("flush_no_out_valid", 64'(cnt), 64'd0);
    chk("flush_quotient_kept", bus.quotient, 64'h8000_0000_0000_0000);
    run_op(64'd100, 64'd7, 1'b0, 1'b0, q, r, lat);
    chk("remu_after_flush", r, 64'd2);

    // flush landing in the DONE cycle of a special-case op
    wait_ready();
    bus.dividend = 64'd5; bus.divisor = 64'd0; bus.div_valid = 1'b1;
    @(posedge clk); #1;
    bus.div_valid = 1'b0;
    bus.flush = 1'b1;
    #1;
    chk("flush_done_no_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_done_ready", 64'(bus.div_ready), 64'd1);
    chk("flush_done_ov_after", 64'(bus.out_valid), 64'd0);

    // flush in the cycle before DONE of a W op: result must not be written
    run_op(64'd100, 64'd7, 1'b0, 1'b0, q, r, lat);
    wait_ready();
    bus.dividend = 64'd1000; bus.divisor = 64'hFFFF_FFFF_FFFF_FFFD;
    bus.divw = 1'b1; bus.div_signed = 1'b1; bus.div_valid = 1'b1;
    @(posedge clk); #1;
    bus.div_valid = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_fix_ready", 64'(bus.div_ready), 64'd1);
    count_ov(40, cnt);
    chk("flush_fix_no_out_valid", 64'(cnt), 64'd0);
    chk("flush_fix_quotient_kept", bus.quotient, 64'd14);
    chk("flush_fix_remainder_kept", bus.remainder, 64'd2);

    // div_valid coinciding with flush is not accepted
    bus.dividend = 64'd1000; bus.divisor = 64'd3; bus.divw = 1'b0; bus.div_signed = 1'b0;
    bus.div_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.div_valid = 1'b0; bus.flush = 1'b0;
    chk("valid_with_flush_ready", 64'(bus.div_ready), 64'd1);
    count_ov(70, cnt);
    chk("valid_with_flush_no_ov", 64'(cnt), 64'd0);

    // div_valid held with new operands while busy is ignored
    wait_ready();
    bus.dividend = 64'd1000; bus.divisor = 64'd3; bus.div_valid = 1'b1;
    @(posedge clk); #1;
    bus.dividend = 64'd77; bus.divisor = 64'd5;
    chk("busy_not_ready", 64'(bus.div_ready), 64'd0);
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      if (bus.out_valid) begin
        lat = k; q = bus.quotient; r = bus.remainder;
        break;
      end
      @(posedge clk); #1;
    end
    bus.div_valid = 1'b0;
    chk("busy_ignore_latency", 64'(lat), 64'd66);
    chk("busy_ignore_quotient", q, 64'd333);
    chk("busy_ignore_remainder", r, 64'd1);
    @(posedge clk); #1;
    chk("busy_ignore_ready_after", 64'(bus.div_ready), 64'd1);

    // rst in T+5 of a 64-bit op
    bus.dividend = 64'd1000; bus.divisor = 64'd3; bus.div_valid = 1'b1;
    @(posedge clk); #1;
    bus.div_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_ready", 64'(bus.div_ready), 64'd1);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_quotient", bus.quotient, 64'd0);
    chk("midrst_remainder", bus.remainder, 64'd0);
    count_ov(80, cnt);
    chk("midrst_no_out_valid", 64'(cnt), 64'd0);
    run_op(64'h64, 64'hA, 1'b0, 1'b0, q, r, lat);
    chk("after_rst_quotient", q, 64'hA);
    chk("after_rst_remainder", r, 64'd0);

    // randomized ops against the reference model
    for (int n = 0; n < 50; n++) begin
      w = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin
          b = '1;
          a = w ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
        end
        2: b = 64'($urandom_range(1, 20));
        3: begin
          a = 64'($urandom_range(0, 1000));
          b = {$urandom, $urandom} | 64'h1;
        end
        default: ;
      endcase
      ref_div(a, b, w, s, eq, er, elat);
      run_op(a, b, w, s, q, r, lat);
      chk("rand_quotient", q, eq);
      chk("rand_remainder", r, er);
      chk("rand_latency", 64'(lat), 64'(elat));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
